// File: rtl/nonce_result_arbiter.sv
// Per-core one-entry result slots drained round-robin onto
// a valid/ready nonce-buffer write port, with flush and overflow.
module nonce_result_arbiter #(
  parameter  int NUM_CORES = 10,
  parameter  int NONCE_W   = 32,
  localparam int ID_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [NUM_CORES-1:0]         core_found,
  input  logic [NUM_CORES*NONCE_W-1:0] core_nonce,
  output logic                         nb_valid,
  output logic [NONCE_W-1:0]           nb_nonce,
  output logic [ID_W-1:0]              nb_core_id,
  input  logic                         nb_ready,
  output logic [NUM_CORES-1:0]         pending,
  output logic                         busy,
  output logic                         overflow
);

  logic [NUM_CORES-1:0] pend_q;
  logic [NUM_CORES-1:0] pend_nx;
  logic [NONCE_W-1:0]   slot_q [NUM_CORES];
  logic                 valid_q;
  logic [NONCE_W-1:0]   nonce_q;
  logic [ID_W-1:0]      id_q;
  logic [ID_W-1:0]      ptr_q;
  logic                 ovf_q;
  logic                 load;
  logic                 grant;
  logic                 drop;
  logic [ID_W-1:0]      gidx;
  int                   p;

  always_comb begin
    load    = !valid_q || nb_ready;
    grant   = 1'b0;
    gidx    = '0;
    p       = 0;
    pend_nx = pend_q;
    drop    = 1'b0;
    // first full slot at or after ptr, wrapping at NUM_CORES
    for (int k = 0; k < NUM_CORES; k++) begin
      p = int'(ptr_q) + k;
      if (p >= NUM_CORES) p = p - NUM_CORES;
      if (!grant && pend_q[ID_W'(p)]) begin
        grant = 1'b1;
        gidx  = ID_W'(p);
      end
    end
    grant = grant && load && !flush;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (grant && gidx == ID_W'(i)) begin
        pend_nx[i] = core_found[i];
      end else if (core_found[i]) begin
        if (pend_q[i]) drop = 1'b1;
        pend_nx[i] = 1'b1;
      end
    end
  end

  // a full slot keeps its nonce unless it is being granted
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (core_found[i] && !flush &&
          (!pend_q[i] || (grant && gidx == ID_W'(i))))
        slot_q[i] <= core_nonce[i*NONCE_W +: NONCE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q  <= '0;
      valid_q <= 1'b0;
      nonce_q <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (flush) begin
      pend_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      pend_q <= pend_nx;
      ovf_q  <= ovf_q | drop;
      if (load) begin
        valid_q <= grant;
        if (grant) begin
          nonce_q <= slot_q[gidx];
          id_q    <= gidx;
          ptr_q   <= (gidx == ID_W'(NUM_CORES - 1)) ?
                     '0 : gidx + 1'b1;
        end
      end
    end
  end

  assign nb_valid   = valid_q;
  assign nb_nonce   = nonce_q;
  assign nb_core_id = id_q;
  assign pending    = pend_q;
  assign overflow   = ovf_q;
  assign busy       = valid_q | (|pend_q);

endmodule

// File: tb/tb_nonce_result_arbiter.sv
// Scenario bench for nonce_result_arbiter: expected results are
// queued at stimulus time and compared when a transfer occurs.
module tb_nonce_result_arbiter;

  localparam int N  = 10;
  localparam int W  = 32;
  localparam int IW = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           flush;
  logic [N-1:0]   core_found;
  logic [N*W-1:0] core_nonce;
  logic           nb_valid;
  logic [W-1:0]   nb_nonce;
  logic [IW-1:0]  nb_core_id;
  logic           nb_ready;
  logic [N-1:0]   pending;
  logic           busy;
  logic           overflow;

  int n_cmp = 0;
  int n_err = 0;
  logic [IW+W-1:0] exp_q [$];

  always #5 clk = ~clk;

  nonce_result_arbiter #(.NUM_CORES(N), .NONCE_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .core_found (core_found),
    .core_nonce (core_nonce),
    .nb_valid   (nb_valid),
    .nb_nonce   (nb_nonce),
    .nb_core_id (nb_core_id),
    .nb_ready   (nb_ready),
    .pending    (pending),
    .busy       (busy),
    .overflow   (overflow)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic find(input int i, input logic [W-1:0] v,
                      input bit push);
    core_found[i] = 1'b1;
    core_nonce[i*W +: W] = v;
    if (push) exp_q.push_back({IW'(i), v});
  endtask

  task automatic pop_exp(output logic [IW+W-1:0] e);
    if (exp_q.size() == 0) e = 'x;
    else e = exp_q.pop_front();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    n_cmp++;
    if ({nb_valid, nb_nonce, nb_core_id, pending, busy, overflow}
        !== '0) begin
      n_err++;
      $display("FAIL reset: valid=%b nonce=%h id=%0d pend=%b busy=%b ovf=%b, need all 0",
               nb_valid, nb_nonce, nb_core_id, pending, busy, overflow);
    end
  endtask

  task automatic test_single;
    logic [IW+W-1:0] e;
    nb_ready = 1'b1;
    find(3, 32'hDEADBEEF, 1);
    tick;
    core_found = '0;
    n_cmp++;
    if (pending !== 10'b0000001000 || nb_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_pend: pend=%b valid=%b need pend=0000001000 valid=0",
               pending, nb_valid);
    end
    tick;
    pop_exp(e);
    n_cmp++;
    if (nb_valid !== 1'b1 || {nb_core_id, nb_nonce} !== e) begin
      n_err++;
      $display("FAIL single_out: valid=%b id/nonce=%h need 1/%h",
               nb_valid, {nb_core_id, nb_nonce}, e);
    end
    tick;
    n_cmp++;
    if (nb_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL single_idle: valid=%b busy=%b ovf=%b need 0 0 0",
               nb_valid, busy, overflow);
    end
  endtask

  task automatic test_fair_drain;
    logic [IW+W-1:0] e;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    nb_ready = 1'b1;
    for (int i = 0; i < N; i++) find(i, 32'h100 + i, 1);
    tick;
    core_found = '0;
    tick;
    for (int k = 0; k < N; k++) begin
      pop_exp(e);
      n_cmp++;
      if (nb_valid !== 1'b1 || {nb_core_id, nb_nonce} !== e) begin
        n_err++;
        $display("FAIL drain0_%0d: valid=%b id/nonce=%h need 1/%h",
                 k, nb_valid, {nb_core_id, nb_nonce}, e);
      end
      tick;
    end
    n_cmp++;
    if (nb_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain0_end: valid=%b need 0", nb_valid);
    end
    find(6, 32'h0000_0600, 1);
    tick;
    core_found = '0;
    tick;
    pop_exp(e);
    n_cmp++;
    if (nb_valid !== 1'b1 || {nb_core_id, nb_nonce} !== e) begin
      n_err++;
      $display("FAIL core6: valid=%b id/nonce=%h need 1/%h",
               nb_valid, {nb_core_id, nb_nonce}, e);
    end
    tick;
    for (int k = 0; k < N; k++) find((7 + k) % N, 32'h100 + ((7 + k) % N), 1);
    tick;
    core_found = '0;
    tick;
    for (int k = 0; k < N; k++) begin
      pop_exp(e);
      n_cmp++;
      if (nb_valid !== 1'b1 || {nb_core_id, nb_nonce} !== e) begin
        n_err++;
        $display("FAIL drain7_%0d: valid=%b id/nonce=%h need 1/%h",
                 k, nb_valid, {nb_core_id, nb_nonce}, e);
      end
      tick;
    end
    n_cmp++;
    if (nb_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain7_end: valid=%b need 0", nb_valid);
    end
  endtask

  task automatic test_backpressure;
    logic [IW+W-1:0] e;
    nb_ready = 1'b0;
    find(2, 32'h2222_0002, 1);
    find(5, 32'h5555_0005, 1);
    tick;
    core_found = '0;
    tick;
    for (int c = 0; c < 20; c++) begin
      n_cmp++;
      if (nb_valid !== 1'b1 || nb_nonce !== 32'h2222_0002 ||
          nb_core_id !== 4'd2) begin
        n_err++;
        $display("FAIL stall_%0d: valid=%b nonce=%h id=%0d need 1 22220002 2",
                 c, nb_valid, nb_nonce, nb_core_id);
      end
      if (c == 5) find(5, 32'h5555_9999, 0);
      if (c == 6) core_found = '0;
      tick;
    end
    n_cmp++;
    if (overflow !== 1'b1 || pending !== 10'b0000100000) begin
      n_err++;
      $display("FAIL stall_ovf: ovf=%b pend=%b need 1 0000100000",
               overflow, pending);
    end
    nb_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      pop_exp(e);
      n_cmp++;
      if (nb_valid !== 1'b1 || {nb_core_id, nb_nonce} !== e) begin
        n_err++;
        $display("FAIL release_%0d: valid=%b id/nonce=%h need 1/%h",
                 k, nb_valid, {nb_core_id, nb_nonce}, e);
      end
      tick;
    end
    n_cmp++;
    if (nb_valid !== 1'b0) begin
      n_err++;
      $display("FAIL release_end: valid=%b need 0", nb_valid);
    end
  endtask

  task automatic test_refill;
    logic [IW+W-1:0] e;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL flush_ovf: ovf=%b need 0", overflow);
    end
    nb_ready = 1'b1;
    find(4, 32'h4444_0004, 1);
    tick;
    find(4, 32'hAAAA_0004, 1);
    tick;
    core_found = '0;
    n_cmp++;
    if (pending !== 10'b0000010000) begin
      n_err++;
      $display("FAIL refill_pend: pend=%b need 0000010000", pending);
    end
    for (int k = 0; k < 2; k++) begin
      pop_exp(e);
      n_cmp++;
      if (nb_valid !== 1'b1 || {nb_core_id, nb_nonce} !== e) begin
        n_err++;
        $display("FAIL refill_%0d: valid=%b id/nonce=%h need 1/%h",
                 k, nb_valid, {nb_core_id, nb_nonce}, e);
      end
      tick;
    end
    n_cmp++;
    if (nb_valid !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL refill_end: valid=%b ovf=%b need 0 0",
               nb_valid, overflow);
    end
  endtask

  task automatic test_flush;
    logic [IW+W-1:0] e;
    nb_ready = 1'b0;
    find(0, 32'h0000_00A0, 0);
    find(3, 32'h0000_00A3, 0);
    find(7, 32'h0000_00A7, 0);
    find(8, 32'h0000_00A8, 0);
    tick;
    core_found = '0;
    tick;
    n_cmp++;
    if (nb_valid !== 1'b1 || $countones(pending) != 3) begin
      n_err++;
      $display("FAIL flush_setup: valid=%b pend=%b need 1 and 3 pending",
               nb_valid, pending);
    end
    find(0, 32'h0000_00B0, 0);
    tick;
    core_found = '0;
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_err++;
      $display("FAIL flush_preovf: ovf=%b need 1", overflow);
    end
    flush = 1'b1;
    find(1, 32'h0000_1111, 0);
    tick;
    flush = 1'b0;
    core_found = '0;
    n_cmp++;
    if (nb_valid !== 1'b0 || pending !== '0 || overflow !== 1'b0 ||
        busy !== 1'b0) begin
      n_err++;
      $display("FAIL flush_clr: valid=%b pend=%b ovf=%b busy=%b need 0",
               nb_valid, pending, overflow, busy);
    end
    tick;
    n_cmp++;
    if (pending !== '0 || nb_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_lost: pend=%b valid=%b need 0 0",
               pending, nb_valid);
    end
    nb_ready = 1'b1;
    find(1, 32'h1111_0001, 1);
    tick;
    core_found = '0;
    tick;
    pop_exp(e);
    n_cmp++;
    if (nb_valid !== 1'b1 || {nb_core_id, nb_nonce} !== e) begin
      n_err++;
      $display("FAIL flush_after: valid=%b id/nonce=%h need 1/%h",
               nb_valid, {nb_core_id, nb_nonce}, e);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    logic [IW+W-1:0] e;
    nb_ready = 1'b0;
    find(2, 32'h0000_C002, 0);
    find(5, 32'h0000_C005, 0);
    tick;
    core_found = '0;
    tick;
    n_cmp++;
    if (nb_valid !== 1'b1 || pending === '0) begin
      n_err++;
      $display("FAIL rstmid_setup: valid=%b pend=%b need 1 and nonzero",
               nb_valid, pending);
    end
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    n_cmp++;
    if ({nb_valid, nb_nonce, nb_core_id, pending, busy, overflow}
        !== '0) begin
      n_err++;
      $display("FAIL rstmid: valid=%b nonce=%h id=%0d pend=%b busy=%b ovf=%b, need all 0",
               nb_valid, nb_nonce, nb_core_id, pending, busy, overflow);
    end
    nb_ready = 1'b1;
    tick;
    tick;
    n_cmp++;
    if (nb_valid !== 1'b0 || pending !== '0) begin
      n_err++;
      $display("FAIL rstmid_replay: valid=%b pend=%b need 0 0",
               nb_valid, pending);
    end
    find(9, 32'h9999_0009, 1);
    tick;
    core_found = '0;
    tick;
    pop_exp(e);
    n_cmp++;
    if (nb_valid !== 1'b1 || {nb_core_id, nb_nonce} !== e) begin
      n_err++;
      $display("FAIL rstmid_core9: valid=%b id/nonce=%h need 1/%h",
               nb_valid, {nb_core_id, nb_nonce}, e);
    end
    tick;
  endtask

  initial begin
    rst_n      = 1'b1;
    flush      = 1'b0;
    nb_ready   = 1'b0;
    core_found = '0;
    core_nonce = '0;
    @(negedge clk);
    test_reset;
    test_single;
    test_fair_drain;
    test_backpressure;
    test_refill;
    test_flush;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nonce_result_arbiter.md
# nonce_result_arbiter

Collects winning-nonce reports from the NUM_CORES hashing cores inside the miner and serialises them, one per cycle at most, onto the nonce-buffer write port. Each core gets a one-entry holding slot, so simultaneous finds are never lost while the slot is free. A round-robin grant prevents any core from starving the others. A flush, pulsed on every new block broadcast, discards stale results.

## Interface
- NUM_CORES, 10, number of hashing cores (1..256)
- NONCE_W, 32, nonce width in bits
- ID_W, $clog2(NUM_CORES) (min 1), core-index width; derived, not overridden
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  one-cycle pulse: discard all pending and presented results
- core_found  in  NUM_CORES  bit i = core i reports a nonce this cycle (pulse)
- core_nonce  in  NUM_CORES*NONCE_W  core i nonce at bits [i*NONCE_W +: NONCE_W]; sampled only with core_found[i]
- nb_valid  out  1  output holds a result
- nb_nonce  out  NONCE_W  presented nonce
- nb_core_id  out  ID_W  index of the originating core
- nb_ready  in  1  nonce buffer accepts this cycle
- pending  out  NUM_CORES  slot-occupied flags
- busy  out  1  nb_valid OR any pending bit
- overflow  out  1  sticky: at least one report was dropped since reset or the last flush

## Operation
- Slot i states: EMPTY and FULL. EMPTY→FULL on core_found[i]. FULL→EMPTY when the slot is granted. FULL with core_found[i] and no grant → report dropped; slot keeps its old nonce; overflow set.
- Same-cycle grant and core_found[i] on slot i: old nonce moves to the output, new nonce captured; slot stays FULL; no overflow.
- Output register load condition: load = !nb_valid OR nb_ready. When load is true and any slot is FULL, grant the first FULL slot in round-robin order starting at ptr.
- On a grant: output register takes that slot's nonce and index; ptr becomes (granted index + 1) mod NUM_CORES.
- When load is true and no slot is FULL, nb_valid goes 0 next cycle.
- No grant occurs while load is false. ptr is unchanged without a grant.
- Handshake: a transfer completes on a cycle where nb_valid and nb_ready are both 1. nb_nonce and nb_core_id are held stable while nb_valid and !nb_ready. nb_valid never drops without a transfer, except on flush or reset.
- Flush has priority over every other event in its cycle. On the next edge: all slots EMPTY, nb_valid=0, overflow=0. core_found in the flush cycle is ignored and does not set overflow. ptr is not changed.
- Reset values (rst_n low at an edge): pending=0, nb_valid=0, nb_nonce=0, nb_core_id=0, overflow=0, ptr=0, busy=0. Reset mid-transfer discards everything; nothing is replayed.
- nb_ready while nb_valid=0 is ignored.

## Timing
- All outputs are registered except busy, which is combinational from registered state.
- Latency from core_found[i] at edge T: pending[i]=1 after T. If the output is free and slot i wins arbitration, nb_valid=1 with the nonce after T+1 (2 cycles).
- Throughput: 1 result per cycle with nb_ready held high.
- Worst-case wait for a FULL slot: NUM_CORES grants.
- ptr wraps from NUM_CORES-1 to 0, including for non-power-of-2 NUM_CORES.

## Test plan
- Single find: NUM_CORES=10, reset, core_found[3]=1 with nonce 0xDEADBEEF, nb_ready=1 → nb_valid=1, nb_nonce=0xDEADBEEF, nb_core_id=3 two cycles later. Then nb_valid=0, busy=0, overflow=0.
- Fair drain: all 10 cores find simultaneously (nonce = 0x100+i), nb_ready=1 → 10 consecutive transfers with core ids 0,1,…,9, no gaps. Repeat with ptr=7 (after granting core 6) → order 7,8,9,0,…,6.
- Backpressure: nb_ready=0 for 20 cycles with cores 2 and 5 pending → nb_nonce/nb_core_id stay at core 2 for all 20 cycles. Release → core 2 then core 5 on the next two cycles. A second core_found[5] during the stall → overflow=1, and core 5's first nonce is delivered.
- Refill on grant: core 4 slot FULL and granted in the same cycle core_found[4] fires with 0xAAAA0004 → both nonces delivered in order, overflow=0.
- Flush: 3 pending plus a stalled output, pulse flush together with core_found[1] → next cycle nb_valid=0, pending=0, overflow=0. Core 1's report is lost. A subsequent find is delivered normally.
- Reset mid-operation: rst_n=0 for one edge while nb_valid=1 and pending≠0 → all outputs at reset values. After release, a find on core 9 is granted first.
